// File: rtl/demux_lane_collector.sv
// demux_lane_collector: per-lane WIDTH-bit word assembly behind the 1-to-4 demux, drained round-robin.
// Define COLLECTOR_PARITY_EN to add the registered out_parity port.
module demux_lane_collector #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             bit_vld,
    input  logic [1:0]       sel,
    input  logic [3:0]       din,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [1:0]       out_lane,
`ifdef COLLECTOR_PARITY_EN
    output logic             out_parity,
`endif
    output logic [3:0]       ovf,
    input  logic             ovf_clr
);
    localparam int CW = $clog2(WIDTH);

    logic [WIDTH-2:0] sh   [4];
    logic [CW-1:0]    cnt  [4];
    logic [WIDTH-1:0] hold [4];
    logic [3:0]       full;
    logic [1:0]       last_grant;

    logic [WIDTH-1:0] word;
    logic [3:0]       done;
    logic [3:0]       drain;
    logic             free;
    logic             found;
    logic             load;
    logic [1:0]       gnt;
    logic [1:0]       cand;

    always_comb begin
        word = {sh[sel], din[sel]};
        done = '0;
        for (int unsigned l = 0; l < 4; l++) begin
            done[l] = bit_vld && (sel == 2'(l)) && (cnt[l] == CW'(WIDTH - 1));
        end
    end

    // Search starts one past the last grant; the i=4 step wraps back onto last_grant itself.
    always_comb begin
        free  = !out_valid || out_ready;
        found = 1'b0;
        gnt   = '0;
        cand  = '0;
        for (int unsigned i = 1; i <= 4; i++) begin
            cand = last_grant + 2'(i);
            if (!found && full[cand]) begin
                found = 1'b1;
                gnt   = cand;
            end
        end
        load  = free && found;
        drain = '0;
        for (int unsigned l = 0; l < 4; l++) begin
            drain[l] = load && (gnt == 2'(l));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned l = 0; l < 4; l++) begin
                sh[l]   <= '0;
                cnt[l]  <= '0;
                hold[l] <= '0;
            end
            full <= '0;
            ovf  <= '0;
        end else begin
            if (bit_vld) begin
                if (done[sel]) begin
                    cnt[sel] <= '0;
                end else begin
                    sh[sel]  <= word[WIDTH-2:0];
                    cnt[sel] <= cnt[sel] + CW'(1);
                end
            end
            for (int unsigned l = 0; l < 4; l++) begin
                // A hold slot being drained this edge can take the newly finished word.
                if (done[l] && (!full[l] || drain[l])) begin
                    hold[l] <= word;
                    full[l] <= 1'b1;
                end else if (drain[l]) begin
                    full[l] <= 1'b0;
                end
                if (done[l] && full[l] && !drain[l]) begin
                    ovf[l] <= 1'b1;
                end else if (ovf_clr) begin
                    ovf[l] <= 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid  <= 1'b0;
            out_data   <= '0;
            out_lane   <= '0;
            last_grant <= 2'd3;
`ifdef COLLECTOR_PARITY_EN
            out_parity <= 1'b0;
`endif
        end else if (free) begin
            if (found) begin
                out_valid  <= 1'b1;
                out_data   <= hold[gnt];
                out_lane   <= gnt;
                last_grant <= gnt;
`ifdef COLLECTOR_PARITY_EN
                out_parity <= ^hold[gnt];
`endif
            end else begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_demux_lane_collector.sv
// Scoreboard bench for demux_lane_collector: directed words pushed as expectations, monitor pops on handshake.
module tb_demux_lane_collector;
    localparam int WIDTH = 8;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             bit_vld;
    logic [1:0]       sel;
    logic [3:0]       din;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic [1:0]       out_lane;
    logic [3:0]       ovf;
    logic             ovf_clr;
`ifdef COLLECTOR_PARITY_EN
    logic             out_parity;
`endif

    int tests = 0;
    int fails = 0;
    logic [WIDTH+1:0] expq [$];

    always #5 clk = ~clk;

    demux_lane_collector #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bit_vld   (bit_vld),
        .sel       (sel),
        .din       (din),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_lane  (out_lane),
`ifdef COLLECTOR_PARITY_EN
        .out_parity(out_parity),
`endif
        .ovf       (ovf),
        .ovf_clr   (ovf_clr)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    task automatic push(input logic [1:0] l, input logic [WIDTH-1:0] d);
        expq.push_back({l, d});
    endtask

    // Unselected lanes carry the inverse bit so any leakage from them corrupts the word.
    task automatic drive_bit(input logic [1:0] l, input logic b);
        bit_vld = 1'b1;
        sel     = l;
        din     = {4{~b}};
        din[l]  = b;
        @(posedge clk); #1;
        bit_vld = 1'b0;
        din     = '0;
    endtask

    task automatic send_word(input logic [1:0] l, input logic [WIDTH-1:0] w,
                             input logic clr_last, input logic rdy_last);
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (i == 0) begin
                if (clr_last) ovf_clr = 1'b1;
                if (rdy_last) out_ready = 1'b1;
            end
            drive_bit(l, w[i]);
        end
        ovf_clr = 1'b0;
    endtask

    task automatic wait_drain(input int budget);
        int n = 0;
        while (expq.size() != 0 && n < budget) begin
            @(posedge clk);
            n++;
        end
        tests++;
        if (expq.size() != 0) begin
            fails++;
            $display("FAIL drain_timeout: %0d words still pending, required 0", expq.size());
            expq.delete();
        end
        repeat (3) @(posedge clk);
        #1;
    endtask

    // Monitor: pops on every handshake and checks hold-stability while stalled.
    initial begin
        logic [WIDTH+1:0] e;
        logic [WIDTH-1:0] pdata;
        logic [1:0]       plane;
        logic             stalled;
        stalled = 1'b0;
        pdata   = '0;
        plane   = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                stalled = 1'b0;
            end else begin
                if (stalled) begin
                    check("stall_valid", out_valid, 1);
                    check("stall_data", out_data, pdata);
                    check("stall_lane", out_lane, plane);
                end
                if (out_valid && out_ready) begin
                    if (expq.size() == 0) begin
                        tests++;
                        fails++;
                        $display("FAIL unexpected_word: got lane %0d data %0h, required no word", out_lane, out_data);
                    end else begin
                        e = expq.pop_front();
                        check("sb_lane", out_lane, e[WIDTH+1:WIDTH]);
                        check("sb_data", out_data, e[WIDTH-1:0]);
`ifdef COLLECTOR_PARITY_EN
                        check("sb_parity", out_parity, ^e[WIDTH-1:0]);
`endif
                    end
                end
                stalled = out_valid && !out_ready;
                pdata   = out_data;
                plane   = out_lane;
            end
        end
    end

    initial begin
        rst_n     = 1'b0;
        bit_vld   = 1'b0;
        sel       = '0;
        din       = '0;
        out_ready = 1'b1;
        ovf_clr   = 1'b0;
        #1;
        check("rst_valid", out_valid, 0);
        check("rst_data", out_data, 0);
        check("rst_lane", out_lane, 0);
        check("rst_ovf", ovf, 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;

        // Single word on lane 2, latency of two cycles
        push(2'd2, 8'hB2);
        send_word(2'd2, 8'hB2, 1'b0, 1'b0);
        check("lat_e_valid", out_valid, 0);
        @(posedge clk); #1;
        check("lat_e1_valid", out_valid, 1);
        check("single_data", out_data, 8'hB2);
        check("single_lane", out_lane, 2);
        check("single_ovf", ovf, 0);
        wait_drain(20);

        // Interleaved lanes 0 (ones) and 1 (zeros)
        push(2'd0, 8'hFF);
        push(2'd1, 8'h00);
        for (int i = 0; i < WIDTH; i++) begin
            drive_bit(2'd0, 1'b1);
            drive_bit(2'd1, 1'b0);
        end
        wait_drain(20);

        // Round robin: lane 0 goes straight out, lanes 3 then 1 wait in hold
        out_ready = 1'b0;
        push(2'd0, 8'h11);
        push(2'd1, 8'h22);
        push(2'd3, 8'h33);
        send_word(2'd0, 8'h11, 1'b0, 1'b0);
        send_word(2'd3, 8'h33, 1'b0, 1'b0);
        send_word(2'd1, 8'h22, 1'b0, 1'b0);
        out_ready = 1'b1;
        wait_drain(20);

        // last_grant=3: lane 0 outranks lane 3 even though lane 3 filled first
        out_ready = 1'b0;
        push(2'd3, 8'h3C);
        push(2'd0, 8'h0F);
        push(2'd3, 8'hC3);
        send_word(2'd3, 8'h3C, 1'b0, 1'b0);
        send_word(2'd3, 8'hC3, 1'b0, 1'b0);
        send_word(2'd0, 8'h0F, 1'b0, 1'b0);
        out_ready = 1'b1;
        wait_drain(20);
        check("rr_ovf", ovf, 0);

        // Backpressure and overflow on lane 1
        out_ready = 1'b0;
        push(2'd1, 8'hA1);
        push(2'd1, 8'h5E);
        send_word(2'd1, 8'hA1, 1'b0, 1'b0);
        send_word(2'd1, 8'h5E, 1'b0, 1'b0);
        send_word(2'd1, 8'h3D, 1'b0, 1'b0);
        check("bp_valid", out_valid, 1);
        check("bp_data", out_data, 8'hA1);
        check("bp_lane", out_lane, 1);
        check("bp_ovf", ovf, 4'b0010);
        @(posedge clk); #1;
        check("ovf_sticky", ovf, 4'b0010);
        ovf_clr = 1'b1;
        @(posedge clk); #1;
        ovf_clr = 1'b0;
        check("ovf_clr", ovf, 0);
        send_word(2'd1, 8'h96, 1'b1, 1'b0);
        check("ovf_set_wins", ovf, 4'b0010);
        ovf_clr = 1'b1;
        @(posedge clk); #1;
        ovf_clr = 1'b0;
        check("ovf_clr2", ovf, 0);
        out_ready = 1'b1;
        wait_drain(20);

        // Drain-and-fill on lane 1 on the same edge
        out_ready = 1'b0;
        push(2'd1, 8'h81);
        push(2'd1, 8'h7E);
        push(2'd1, 8'hC6);
        send_word(2'd1, 8'h81, 1'b0, 1'b0);
        send_word(2'd1, 8'h7E, 1'b0, 1'b0);
        send_word(2'd1, 8'hC6, 1'b0, 1'b1);
        check("df_ovf", ovf, 0);
        wait_drain(20);

        // Reset mid-word with a stalled output and a set ovf bit
        out_ready = 1'b0;
        send_word(2'd2, 8'hC3, 1'b0, 1'b0);
        send_word(2'd2, 8'hC3, 1'b0, 1'b0);
        send_word(2'd2, 8'hC3, 1'b0, 1'b0);
        check("pre_rst_ovf", ovf, 4'b0100);
        for (int i = 0; i < 5; i++) drive_bit(2'd0, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_valid", out_valid, 0);
        check("mid_rst_data", out_data, 0);
        check("mid_rst_lane", out_lane, 0);
        check("mid_rst_ovf", ovf, 0);
`ifdef COLLECTOR_PARITY_EN
        check("mid_rst_parity", out_parity, 0);
`endif
        @(posedge clk); #1;
        rst_n = 1'b1;
        out_ready = 1'b1;
        push(2'd0, 8'h5A);
        send_word(2'd0, 8'h5A, 1'b0, 1'b0);
        @(posedge clk); #1;
        check("post_rst_valid", out_valid, 1);
        check("post_rst_data", out_data, 8'h5A);
`ifdef COLLECTOR_PARITY_EN
        check("post_rst_parity", out_parity, 0);
`endif
        wait_drain(20);

        check("queue_empty", expq.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/demux_lane_collector.md
# demux_lane_collector

Downstream stage of the 1-to-4 bit demultiplexer. It samples the four demux output lanes, assembles a WIDTH-bit word independently per lane and buffers one finished word per lane. It presents completed words to a single consumer over a valid/ready handshake, using a round-robin order across lanes, and it flags per-lane overflow when a lane finishes a word while its buffer is still occupied.

## Interface
Parameters:
- WIDTH, 8, bits per assembled word; legal range 2..32.

Ports:
- clk  input  1  single clock; all state changes on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- bit_vld  input  1  a demux bit is present this cycle.
- sel  input  2  lane select that is driving the demux this cycle.
- din  input  4  demux output lanes; the sampled bit is din[sel].
- out_valid  output  1  out_data and out_lane hold a finished word.
- out_ready  input  1  the consumer accepts the word.
- out_data  output  WIDTH  assembled word, first-received bit in the MSB.
- out_lane  output  2  lane index of out_data.
- ovf  output  4  sticky per-lane overflow flags.
- ovf_clr  input  1  clears all ovf bits.

## Operation
- Per-lane state: shift register sh[l] (WIDTH-1 bits), bit counter cnt[l] (0..WIDTH-1), holding register hold[l] (WIDTH bits), flag full[l].
- Bit capture when bit_vld=1, with l=sel and b=din[sel]:
  - If cnt[l] < WIDTH-1: sh[l] <= {sh[l], b} and cnt[l]++.
  - Else the word {sh[l], b} completes and cnt[l] <= 0.
  - Other lanes are unaffected.
  - din bits other than din[sel] are ignored.
- Word completion on lane l:
  - If full[l]=0, or full[l] is being drained into the output register this same cycle, then hold[l] <= word and full[l] <= 1.
  - Otherwise the word is dropped, hold[l] is unchanged, and ovf[l] <= 1.
- Output register (out_data, out_lane, out_valid):
  - It is free when out_valid=0, or when out_valid=1 and out_ready=1.
  - When free, the arbiter grants the first lane with full=1, searching from (last_grant+1) mod 4 upward with wrap.
  - The granted hold word and lane index load into the output register, out_valid <= 1 and full[granted] <= 0.
  - When free and no lane is full, out_valid <= 0.
  - last_grant updates only on a load.
- Handshake: while out_valid=1 and out_ready=0, out_data and out_lane hold stable. out_valid never deasserts without a handshake.
- Overflow: ovf bits are sticky. ovf_clr=1 clears them on the next edge. A set on the same edge as ovf_clr wins for that lane.
- Reset (asynchronous, any time, including mid-word):
  - sh, cnt, hold, full, out_data, out_lane, out_valid and ovf all go to 0.
  - last_grant goes to 3, so lane 0 has first priority.
  - Partial words are discarded.

## Timing
- A word whose last bit is sampled at edge E is in hold after E. If the output register is free at E+1, out_valid=1 after edge E+1. Minimum latency is 2 cycles from the final bit_vld cycle to out_valid.
- Sustained throughput is one word per cycle when out_ready=1.
- Bit capture needs no ready signal; the upstream stage is never stalled.
- Every output is registered; there is no combinational path from input to output.

## Configuration
- COLLECTOR_PARITY_EN defined:
  - Adds port out_parity (output, 1 bit) equal to the XOR of out_data.
  - out_parity is registered together with out_data and follows the same stability rule.
  - It resets to 0.
- COLLECTOR_PARITY_EN undefined: the port and its logic are absent; all other behaviour is identical.

## Test plan
- Single-lane word (WIDTH=8):
  - Stimulus: sel=2, din[2] = 1,0,1,1,0,0,1,0 on consecutive bit_vld cycles, out_ready=1.
  - Required: out_valid=1 two cycles after the last bit, with out_data=8'hB2, out_lane=2, ovf=0.
- Interleaved lanes:
  - Stimulus: alternate sel 0/1 per bit, lane 0 all ones, lane 1 all zeros.
  - Required: lane 0 yields 8'hFF and lane 1 yields 8'h00, each correct and in completion order.
- Round-robin order:
  - Stimulus: fill hold on lanes 0, 1 and 3 with out_ready=0, then raise out_ready.
  - Required: out_lane sequence 0,1,3.
  - Then refill lanes 0 and 3 with last_grant=3. Required: order 0,3.
- Backpressure and overflow:
  - Stimulus: hold out_ready=0, complete 3 words on lane 1.
  - Required: output word is the first word, out_data stays stable, hold keeps the second word, ovf[1]=1 and the third word is lost.
  - Then pulse ovf_clr. Required: ovf=0.
- Drain-and-fill same cycle:
  - Stimulus: the lane 1 handshake (load from hold[1]) happens on the same edge that lane 1 completes a new word.
  - Required: the new word is accepted and ovf[1] stays 0.
- Reset mid-word:
  - Stimulus: assert rst_n=0 after 5 bits on lane 0, then send 8 fresh bits 8'h5A.
  - Required: all outputs are 0 during reset, then out_data=8'h5A. With COLLECTOR_PARITY_EN defined, out_parity=0.
